branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter KILL_SLOTS, default 2: number of wrong-path beats dropped after a redirect (range 1-7).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: value of redirect_pc and out_target after reset.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 in_valid/in_ready  in/out  1/1  upstream handshake; a beat transfers when both are high at a rising edge.
REQ-006 in_pc, in_rs1, in_rs2, in_imm  in  32 each  instruction PC, operands, sign-extended immediate.
REQ-007 in_funct3  in  3  branch condition select.
REQ-008 in_is_branch, in_is_jal, in_is_jalr  in  1 each  one-hot or all-zero op class; all-zero means non-control beat.
REQ-009 out_valid/out_ready  out/in  1/1  downstream handshake.
REQ-010 out_taken, out_illegal, out_misalign  out  1 each  resolved result flags.
REQ-011 out_target, out_link  out  32 each  resolved target; link value pc+4.
REQ-012 redirect_valid  out  1  single-cycle fetch redirect pulse; redirect_pc  out  32  new fetch PC.

Function
REQ-013 SHALL be a one-entry registered stage with latency 1 and in_ready = !out_valid || out_ready.
REQ-014 Conditions SHALL be: 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE.
REQ-015 Signed compare SHALL reuse the unsigned comparator with bit 31 of both operands inverted.
REQ-016 in_funct3 010/011 with in_is_branch SHALL give out_illegal=1, out_taken=0, and no redirect.
REQ-017 jal and jalr SHALL be unconditionally taken; non-control beats SHALL give out_taken=0.
REQ-018 Target: branch/jal = in_pc+in_imm; jalr = (in_rs1+in_imm) with bit 0 cleared. All arithmetic is modulo 2^32 and wraps silently.
REQ-019 out_link SHALL be in_pc+4 modulo 2^32 for every beat.
REQ-020 A taken result with target bit 1 set SHALL set out_misalign=1, suppress redirect_valid, and not enter SQUASH.
REQ-021 FSM states SHALL be IDLE and SQUASH. In IDLE, a taken, legal, aligned beat captured at edge N SHALL:
  - assert redirect_valid for exactly the cycle after edge N, with redirect_pc=out_target;
  - load kill_cnt=KILL_SLOTS;
  - enter SQUASH.
REQ-022 In SQUASH, each accepted beat SHALL:
  - be dropped (out_valid not set for it);
  - decrement kill_cnt;
  - return the FSM to IDLE when kill_cnt reaches 0.
REQ-023 In SQUASH, a dropped beat SHALL never raise redirect_valid, even if it is a taken branch.
REQ-024 A downstream stall (out_ready=0) SHALL NOT delay or repeat redirect_valid; the result SHALL be held stable until accepted.
REQ-025 Beats accepted in the same cycle that redirect_valid is high SHALL count as wrong-path.

Reset
REQ-026 On rst, SHALL set:
  - out_valid=0, redirect_valid=0;
  - out_taken=0, out_illegal=0, out_misalign=0;
  - out_target=RESET_PC, redirect_pc=RESET_PC, out_link=0;
  - kill_cnt=0, state=IDLE.
REQ-027 rst SHALL take priority over every simultaneous event, including a pending squash or a redirect pulse; in-flight beats SHALL be discarded.

Structure
REQ-028 The shared RISC-V package SHALL hold the funct3 branch encodings, the FSM state enum, and a typedef for the resolved-result record.
REQ-029 Exactly one sub-module SHALL be instantiated: the existing 32-bit unsigned comparator COMPARATOR_32bits (EQ/NE/GT/LE/LT/GE), driven per REQ-015.

Verification
REQ-030 BEQ, rs1=rs2=32'h0000_0005, pc=32'h100, imm=32'h20 -> out_taken=1, out_target=32'h120, redirect pulse of one cycle, next 2 accepted beats dropped.
REQ-031 BLT, rs1=32'h8000_0000, rs2=32'h7FFF_FFFF -> taken; same operands with BLTU -> not taken, no redirect.
REQ-032 JALR, rs1=32'h0000_1003, imm=32'h1 -> out_target=32'h1004, out_link=pc+4; with imm=32'h0 -> target 32'h1002, out_misalign=1, no redirect.
REQ-033 Taken BNE followed back-to-back by a taken JAL -> exactly one redirect pulse; JAL dropped, with out_ready held 0 for 3 cycles during the redirect cycle.
REQ-034 funct3=010 branch -> out_illegal=1, out_taken=0; pc=32'hFFFF_FFFC -> out_link=32'h0000_0000.
REQ-035 rst asserted while kill_cnt=1 -> next cycle state IDLE, out_valid=0, and the following taken branch redirects normally.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: shared branch encodings, FSM states and resolved-result record
package branch_resolve_unit_pkg;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic {IDLE, SQUASH} state_t;
  typedef struct packed {
    logic        taken;
    logic        illegal;
    logic        misalign;
    logic [31:0] target;
    logic [31:0] link;
  } result_t;
endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: upstream beat, downstream result and fetch redirect bundle
interface branch_resolve_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_imm;
  logic [2:0]  in_funct3;
  logic        in_is_branch;
  logic        in_is_jal;
  logic        in_is_jalr;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic        out_illegal;
  logic        out_misalign;
  logic [31:0] out_target;
  logic [31:0] out_link;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  modport master (
    output in_valid, in_pc, in_rs1, in_rs2, in_imm, in_funct3, in_is_branch, in_is_jal, in_is_jalr, out_ready,
    input  in_ready, out_valid, out_taken, out_illegal, out_misalign, out_target, out_link, redirect_valid, redirect_pc
  );
  modport slave (
    input  in_valid, in_pc, in_rs1, in_rs2, in_imm, in_funct3, in_is_branch, in_is_jal, in_is_jalr, out_ready,
    output in_ready, out_valid, out_taken, out_illegal, out_misalign, out_target, out_link, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/COMPARATOR_32bits.sv
// COMPARATOR_32bits: 32-bit unsigned magnitude comparator
module COMPARATOR_32bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        eq,
  output logic        ne,
  output logic        gt,
  output logic        le,
  output logic        lt,
  output logic        ge
);
  assign eq = a == b;
  assign ne = !eq;
  assign lt = a < b;
  assign ge = !lt;
  assign gt = !lt && !eq;
  assign le = !gt;
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered branch/jump resolver with fetch redirect and wrong-path squash
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int          KILL_SLOTS = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_unit_if.slave bus
);
  state_t      state, state_nxt;
  logic [2:0]  kill_cnt, kill_nxt;
  logic        accept, keep, fire, flip;
  logic        eq, ne, gt, le, lt, ge;
  logic [7:0]  cond_tab;
  logic [31:0] sum, cmp_a, cmp_b, redirect_pc_q;
  logic        out_valid_q, redirect_valid_q;
  result_t     res, res_q;
  // signed LT/GE reuse the unsigned comparator by flipping the sign bits
  assign flip  = bus.in_funct3[2:1] == 2'b10;
  assign cmp_a = bus.in_rs1 ^ {flip, 31'd0};
  assign cmp_b = bus.in_rs2 ^ {flip, 31'd0};
  COMPARATOR_32bits u_cmp (
    .a(cmp_a), .b(cmp_b), .eq(eq), .ne(ne), .gt(gt), .le(le), .lt(lt), .ge(ge)
  );
  // indexed by funct3; the 010/011 slots are illegal and masked below
  assign cond_tab = {ge, lt, ge, lt, le, gt, ne, eq};
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  // resolve the beat currently presented upstream
  always_comb begin
    sum          = (bus.in_is_jalr ? bus.in_rs1 : bus.in_pc) + bus.in_imm;
    res.illegal  = bus.in_is_branch && bus.in_funct3[2:1] == 2'b01;
    res.taken    = bus.in_is_jal || bus.in_is_jalr || (bus.in_is_branch && !res.illegal && cond_tab[bus.in_funct3]);
    res.target   = {sum[31:1], sum[0] && !bus.in_is_jalr};
    res.misalign = res.taken && res.target[1];
    res.link     = bus.in_pc + 32'd4;
  end
  // FSM state and wrong-path counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      kill_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      kill_cnt <= kill_nxt;
    end
  end
  // next state: a redirect arms the squash, the last dropped beat releases it
  always_comb begin
    state_nxt = fire ? SQUASH : (state == SQUASH && accept && kill_cnt == 3'd1) ? IDLE : state;
    kill_nxt  = fire ? 3'(KILL_SLOTS) : (state == SQUASH && accept) ? kill_cnt - 3'd1 : kill_cnt;
  end
  // FSM outputs: only IDLE keeps beats, and only kept taken aligned beats redirect
  always_comb begin
    keep = accept && state == IDLE;
    fire = keep && res.taken && !res.misalign;
  end
  // result hold register and one-cycle redirect pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= RESET_PC;
      res_q            <= '{taken: 1'b0, illegal: 1'b0, misalign: 1'b0, target: RESET_PC, link: 32'd0};
    end else begin
      out_valid_q      <= keep || (out_valid_q && !bus.out_ready);
      redirect_valid_q <= fire;
      if (fire) redirect_pc_q <= res.target;
      if (keep) res_q <= res;
    end
  end
  assign bus.out_valid      = out_valid_q;
  assign bus.out_taken      = res_q.taken;
  assign bus.out_illegal    = res_q.illegal;
  assign bus.out_misalign   = res_q.misalign;
  assign bus.out_target     = res_q.target;
  assign bus.out_link       = res_q.link;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and random checks against a behavioural resolver model
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;
  localparam int          KS  = 2;
  localparam logic [31:0] RPC = 32'h0000_0200;
  typedef struct {
    bit          taken;
    bit          illegal;
    bit          misalign;
    logic [31:0] target;
    logic [31:0] link;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, failures = 0, pulses = 0;
  bit m_ov, m_rv, m_ctrl;
  exp_t m_res;
  logic [31:0] m_rpc;
  int m_skip;
  branch_resolve_unit_if bus();
  branch_resolve_unit #(.KILL_SLOTS(KS), .RESET_PC(RPC)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic exp_t resolve(bit br, bit j, bit jr, logic [2:0] f3, logic [31:0] pc, logic [31:0] rs1,
                                   logic [31:0] rs2, logic [31:0] imm);
    exp_t r;
    logic [31:0] s;
    r.link = pc + 32'd4;
    r.illegal = 1'b0;
    r.taken = 1'b0;
    r.target = pc + imm;
    if (j) r.taken = 1'b1;
    else if (jr) begin
      s = rs1 + imm;
      r.target = {s[31:1], 1'b0};
      r.taken = 1'b1;
    end else if (br) begin
      case (f3)
        3'd0: r.taken = rs1 == rs2;
        3'd1: r.taken = rs1 != rs2;
        3'd4: r.taken = $signed(rs1) < $signed(rs2);
        3'd5: r.taken = $signed(rs1) >= $signed(rs2);
        3'd6: r.taken = rs1 < rs2;
        3'd7: r.taken = rs1 >= rs2;
        default: r.illegal = 1'b1;
      endcase
    end
    r.misalign = r.taken && r.target[1];
    return r;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(bit v, bit br, bit j, bit jr, logic [2:0] f3, logic [31:0] pc, logic [31:0] rs1,
                       logic [31:0] rs2, logic [31:0] imm);
    bus.in_valid = v;
    bus.in_is_branch = br;
    bus.in_is_jal = j;
    bus.in_is_jalr = jr;
    bus.in_funct3 = f3;
    bus.in_pc = pc;
    bus.in_rs1 = rs1;
    bus.in_rs2 = rs2;
    bus.in_imm = imm;
  endtask
  task automatic cycle();
    bit acc, keep, fire;
    exp_t r;
    acc = bus.in_valid && (!m_ov || bus.out_ready);
    r = resolve(bus.in_is_branch, bus.in_is_jal, bus.in_is_jalr, bus.in_funct3, bus.in_pc, bus.in_rs1, bus.in_rs2,
                bus.in_imm);
    @(posedge clk);
    if (rst) begin
      m_ov = 0;
      m_rv = 0;
      m_res = '{0, 0, 0, RPC, 32'd0};
      m_rpc = RPC;
      m_skip = 0;
      m_ctrl = 1;
    end else begin
      keep = acc && m_skip == 0;
      fire = keep && r.taken && !r.misalign;
      if (acc && m_skip > 0) m_skip--;
      m_ov = keep || (m_ov && !bus.out_ready);
      if (keep) begin
        m_res = r;
        m_ctrl = bus.in_is_branch || bus.in_is_jal || bus.in_is_jalr;
      end
      m_rv = fire;
      if (fire) begin
        m_rpc = r.target;
        m_skip = KS;
      end
    end
    #1;
    if (bus.redirect_valid) pulses++;
    chk("out_valid", bus.out_valid, m_ov);
    chk("redirect_valid", bus.redirect_valid, m_rv);
    chk("redirect_pc", bus.redirect_pc, m_rpc);
    chk("out_taken", bus.out_taken, m_res.taken);
    chk("out_illegal", bus.out_illegal, m_res.illegal);
    chk("out_misalign", bus.out_misalign, m_res.misalign);
    chk("out_link", bus.out_link, m_res.link);
    if (m_ctrl) chk("out_target", bus.out_target, m_res.target);
    chk("in_ready", bus.in_ready, !m_ov || bus.out_ready);
  endtask
  task automatic flush(int n);
    for (int i = 0; i < n; i++) begin
      drive(1, 0, 0, 0, 3'd0, 32'h7000 + 32'(4 * i), 0, 0, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
  endtask
  initial begin
    int p0;
    bit [1:0] kind;
    logic [31:0] a;
    bus.out_ready = 1;
    drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    cycle();
    cycle();
    chk("reset_target", bus.out_target, RPC);
    chk("reset_redirect_pc", bus.redirect_pc, RPC);
    rst = 0;
    drive(1, 1, 0, 0, F3_BEQ, 32'h100, 32'h5, 32'h5, 32'h20);
    cycle();
    chk("beq_taken", bus.out_taken, 1);
    chk("beq_target", bus.out_target, 32'h120);
    chk("beq_redirect", bus.redirect_valid, 1);
    flush(2);
    chk("beq_drop_done_valid", bus.out_valid, 0);
    chk("beq_pulse_gone", bus.redirect_valid, 0);
    drive(1, 0, 0, 0, 3'd0, 32'h130, 0, 0, 0);
    cycle();
    chk("after_squash_kept", bus.out_valid, 1);
    drive(1, 1, 0, 0, F3_BLT, 32'h200, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8);
    cycle();
    chk("blt_taken", bus.out_taken, 1);
    flush(2);
    drive(1, 1, 0, 0, F3_BLTU, 32'h200, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8);
    cycle();
    chk("bltu_not_taken", bus.out_taken, 0);
    chk("bltu_no_redirect", bus.redirect_valid, 0);
    drive(1, 0, 0, 1, 3'd0, 32'h300, 32'h1003, 0, 32'h1);
    cycle();
    chk("jalr_target", bus.out_target, 32'h1004);
    chk("jalr_link", bus.out_link, 32'h304);
    flush(2);
    drive(1, 0, 0, 1, 3'd0, 32'h300, 32'h1003, 0, 32'h0);
    cycle();
    chk("jalr_mis_target", bus.out_target, 32'h1002);
    chk("jalr_misalign", bus.out_misalign, 1);
    chk("jalr_mis_no_redirect", bus.redirect_valid, 0);
    p0 = pulses;
    drive(1, 1, 0, 0, F3_BNE, 32'h400, 32'h1, 32'h2, 32'h40);
    cycle();
    drive(1, 0, 1, 0, 3'd0, 32'h404, 0, 0, 32'h100);
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) cycle();
    chk("stall_target_held", bus.out_target, 32'h440);
    bus.out_ready = 1;
    cycle();
    drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    cycle();
    chk("bne_jal_one_pulse", 32'(pulses - p0), 1);
    flush(1);
    drive(1, 1, 0, 0, 3'b010, 32'hFFFF_FFFC, 32'h9, 32'h9, 32'h10);
    cycle();
    chk("illegal_flag", bus.out_illegal, 1);
    chk("illegal_not_taken", bus.out_taken, 0);
    chk("link_wrap", bus.out_link, 32'h0);
    drive(1, 1, 0, 0, F3_BEQ, 32'h500, 32'h3, 32'h3, 32'h10);
    cycle();
    flush(1);
    drive(1, 1, 0, 0, F3_BEQ, 32'h520, 32'h3, 32'h3, 32'h10);
    rst = 1;
    cycle();
    chk("rst_mid_squash_valid", bus.out_valid, 0);
    rst = 0;
    drive(1, 1, 0, 0, F3_BEQ, 32'h600, 32'h3, 32'h3, 32'h8);
    cycle();
    chk("post_rst_redirect", bus.redirect_valid, 1);
    chk("post_rst_redirect_pc", bus.redirect_pc, 32'h608);
    flush(2);
    for (int i = 0; i < 600; i++) begin
      kind = 2'($urandom_range(0, 3));
      a = $urandom;
      drive($urandom_range(0, 3) != 0, kind == 1, kind == 2, kind == 3, 3'($urandom_range(0, 7)), $urandom, a,
            ($urandom_range(0, 2) == 0) ? a : $urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15)));
      bus.out_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 99) == 0;
      cycle();
    end
    rst = 0;
    bus.out_ready = 1;
    drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
